// File: rtl/mem_fwd_watch_pkg.sv
// Shared defaults and types for the data-memory forwarding / watch-mirror unit.
package mem_fwd_watch_pkg;

    localparam int DATA_W_DFLT    = 16;
    localparam int ADDR_W_DFLT    = 15;
    localparam int FWD_DEPTH_DFLT = 2;
    localparam int NUM_WATCH_DFLT = 3;

    localparam logic [3*ADDR_W_DFLT-1:0] WATCH_RST_ADDR_DFLT = {15'd555, 15'd4, 15'd1};

    // Default-width view of one in-flight write; parametrised users keep split arrays.
    typedef struct packed {
        logic                   valid;
        logic [ADDR_W_DFLT-1:0] addr;
        logic [DATA_W_DFLT-1:0] data;
    } t_fwd_entry;

    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_fwd_watch_fwd_prio_sel.sv
// Youngest-first match and select across the in-flight write entries.
module fwd_prio_sel #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
) (
    input  logic [DEPTH-1:0]             valid_i,
    input  logic [DEPTH-1:0][ADDR_W-1:0] addr_i,
    input  logic [DEPTH-1:0][DATA_W-1:0] data_i,
    input  logic [ADDR_W-1:0]            rdAddr_i,
    output logic                         hit_o,
    output logic [DATA_W-1:0]            data_o
);

    // Walk oldest to youngest so the youngest matching entry is assigned last.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (valid_i[k] && (addr_i[k] == rdAddr_i)) begin
                hit_o  = 1'b1;
                data_o = data_i[k];
            end
        end
    end

endmodule

// File: rtl/mem_fwd_watch.sv
// Data-memory write forwarding, reprogrammable address mirrors and a forward-hit counter.
module mem_fwd_watch
    import mem_fwd_watch_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DFLT,
    parameter int ADDR_W    = ADDR_W_DFLT,
    parameter int DEPTH     = FWD_DEPTH_DFLT,
    parameter int NUM_WATCH = NUM_WATCH_DFLT,
    parameter logic [NUM_WATCH*ADDR_W-1:0] WATCH_RST_ADDR = WATCH_RST_ADDR_DFLT,
    parameter int CNT_W     = 16,
    localparam int CIDX_W   = idxWidth(NUM_WATCH)
) (
    input  logic                                clk,
    input  logic                                resetN,
    input  logic                                WrEn102,
    input  logic [ADDR_W-1:0]                   WrAddr102,
    input  logic [DATA_W-1:0]                   WrData102,
    input  logic [ADDR_W-1:0]                   RdAddr102,
    input  logic [DATA_W-1:0]                   RamRdData102,
    output logic [DATA_W-1:0]                   RdData102,
    output logic                                FwdHit102,
    input  logic                                CfgWrEn,
    input  logic [CIDX_W-1:0]                   CfgIdx,
    input  logic [ADDR_W-1:0]                   CfgAddr,
    output logic [NUM_WATCH-1:0][DATA_W-1:0]    WatchData101,
    output logic [NUM_WATCH-1:0]                WatchValid101,
    output logic [NUM_WATCH-1:0][ADDR_W-1:0]    WatchAddr,
    input  logic                                CntClr,
    output logic [CNT_W-1:0]                    FwdHitCnt
);

    logic [DEPTH-1:0]                 entValid_q, entValid_d;
    logic [DEPTH-1:0][ADDR_W-1:0]     entAddr_q,  entAddr_d;
    logic [DEPTH-1:0][DATA_W-1:0]     entData_q,  entData_d;

    logic [NUM_WATCH-1:0][ADDR_W-1:0] watchAddr_q,  watchAddr_d;
    logic [NUM_WATCH-1:0][DATA_W-1:0] watchData_q,  watchData_d;
    logic [NUM_WATCH-1:0]             watchValid_q, watchValid_d;
    logic [NUM_WATCH-1:0]             cfgSel, wrHit;

    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic                             selHit;
    logic [DATA_W-1:0]                selData;

    // Entry k carries the write issued k+1 cycles ago; the current write is never forwarded.
    always_comb begin
        entValid_d[0] = WrEn102;
        entAddr_d[0]  = WrAddr102;
        entData_d[0]  = WrData102;
        for (int k = 1; k < DEPTH; k++) begin
            entValid_d[k] = entValid_q[k-1];
            entAddr_d[k]  = entAddr_q[k-1];
            entData_d[k]  = entData_q[k-1];
        end
    end

    fwd_prio_sel #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_sel (
        .valid_i  (entValid_q),
        .addr_i   (entAddr_q),
        .data_i   (entData_q),
        .rdAddr_i (RdAddr102),
        .hit_o    (selHit),
        .data_o   (selData)
    );

    assign FwdHit102 = selHit;
    assign RdData102 = selHit ? selData : RamRdData102;

    // Config to an index beats a same-cycle write to it and also hides the write-through.
    always_comb begin
        for (int i = 0; i < NUM_WATCH; i++) begin
            cfgSel[i]       = CfgWrEn && (CfgIdx == CIDX_W'(i));
            wrHit[i]        = WrEn102 && (WrAddr102 == watchAddr_q[i]) && !cfgSel[i];
            watchAddr_d[i]  = watchAddr_q[i];
            watchData_d[i]  = watchData_q[i];
            watchValid_d[i] = watchValid_q[i];
            if (cfgSel[i]) begin
                watchAddr_d[i]  = CfgAddr;
                watchData_d[i]  = '0;
                watchValid_d[i] = 1'b0;
            end else if (wrHit[i]) begin
                watchData_d[i]  = WrData102;
                watchValid_d[i] = 1'b1;
            end
            WatchData101[i]  = wrHit[i] ? WrData102 : watchData_q[i];
            WatchValid101[i] = wrHit[i] | watchValid_q[i];
        end
    end

    assign WatchAddr = watchAddr_q;

    always_comb begin
        cnt_d = cnt_q;
        if (CntClr) begin
            cnt_d = '0;
        end else if (FwdHit102 && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign FwdHitCnt = cnt_q;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            entValid_q   <= '0;
            entAddr_q    <= '0;
            entData_q    <= '0;
            watchData_q  <= '0;
            watchValid_q <= '0;
            cnt_q        <= '0;
            for (int i = 0; i < NUM_WATCH; i++) begin
                watchAddr_q[i] <= WATCH_RST_ADDR[i*ADDR_W +: ADDR_W];
            end
        end else begin
            entValid_q   <= entValid_d;
            entAddr_q    <= entAddr_d;
            entData_q    <= entData_d;
            watchAddr_q  <= watchAddr_d;
            watchData_q  <= watchData_d;
            watchValid_q <= watchValid_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_fwd_watch.sv
// Directed bench for mem_fwd_watch with a per-cycle reference model and literal spot checks.
module tb_mem_fwd_watch;
    import mem_fwd_watch_pkg::*;

    localparam int DEPTH = 2;
    localparam int NW    = 3;

    logic              clk = 1'b0;
    logic              resetN;
    logic              WrEn102;
    logic [14:0]       WrAddr102;
    logic [15:0]       WrData102;
    logic [14:0]       RdAddr102;
    logic [15:0]       RamRdData102;
    logic [15:0]       RdData102;
    logic              FwdHit102;
    logic              CfgWrEn;
    logic [1:0]        CfgIdx;
    logic [14:0]       CfgAddr;
    logic [NW-1:0][15:0] WatchData101;
    logic [NW-1:0]       WatchValid101;
    logic [NW-1:0][14:0] WatchAddr;
    logic              CntClr;
    logic [15:0]       FwdHitCnt;

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    mem_fwd_watch dut (
        .clk           (clk),
        .resetN        (resetN),
        .WrEn102       (WrEn102),
        .WrAddr102     (WrAddr102),
        .WrData102     (WrData102),
        .RdAddr102     (RdAddr102),
        .RamRdData102  (RamRdData102),
        .RdData102     (RdData102),
        .FwdHit102     (FwdHit102),
        .CfgWrEn       (CfgWrEn),
        .CfgIdx        (CfgIdx),
        .CfgAddr       (CfgAddr),
        .WatchData101  (WatchData101),
        .WatchValid101 (WatchValid101),
        .WatchAddr     (WatchAddr),
        .CntClr        (CntClr),
        .FwdHitCnt     (FwdHitCnt)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [14:0] wa, input logic [15:0] wd,
                                 input logic [14:0] ra, input logic [15:0] rd);
        @(posedge clk);
        #1;
        resetN       = 1'b1;
        CfgWrEn      = 1'b0;
        CfgIdx       = '0;
        CfgAddr      = '0;
        CntClr       = 1'b0;
        WrEn102      = we;
        WrAddr102    = wa;
        WrData102    = wd;
        RdAddr102    = ra;
        RamRdData102 = rd;
    endtask

    // Reference model: recent-write history (youngest first), watch table and hit count.
    t_fwd_entry  hist[$];
    logic [14:0] mA[NW];
    logic [15:0] mD[NW];
    logic        mV[NW];
    int          mCnt;
    bit          armed = 1'b0;

    always @(negedge clk) begin
        logic              expHit;
        logic [15:0]       expData;
        logic [NW-1:0][15:0] expWD;
        logic [NW-1:0]       expWV;
        logic [NW-1:0][14:0] expWA;
        logic [NW-1:0]       wr, cfg;
        t_fwd_entry        ent;
        if (armed) begin
            expHit  = 1'b0;
            expData = RamRdData102;
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (hist[k].valid && hist[k].addr == RdAddr102) begin
                    expHit  = 1'b1;
                    expData = hist[k].data;
                end
            end
            for (int i = 0; i < NW; i++) begin
                cfg[i]   = CfgWrEn && (int'(CfgIdx) == i);
                wr[i]    = WrEn102 && (WrAddr102 == mA[i]) && !cfg[i];
                expWD[i] = wr[i] ? WrData102 : mD[i];
                expWV[i] = wr[i] | mV[i];
                expWA[i] = mA[i];
            end
            checkOutput("cmp RdData102", 64'(RdData102), 64'(expData));
            checkOutput("cmp FwdHit102", 64'(FwdHit102), 64'(expHit));
            checkOutput("cmp WatchData101", 64'(WatchData101), 64'(expWD));
            checkOutput("cmp WatchValid101", 64'(WatchValid101), 64'(expWV));
            checkOutput("cmp WatchAddr", 64'(WatchAddr), 64'(expWA));
            checkOutput("cmp FwdHitCnt", 64'(FwdHitCnt), 64'(mCnt));
            if (resetN) begin
                ent.valid = WrEn102;
                ent.addr  = WrAddr102;
                ent.data  = WrData102;
                hist.push_front(ent);
                void'(hist.pop_back());
                if (CntClr) mCnt = 0;
                else if (expHit && mCnt < 65535) mCnt++;
                for (int i = 0; i < NW; i++) begin
                    if (cfg[i]) begin
                        mA[i] = CfgAddr;
                        mD[i] = '0;
                        mV[i] = 1'b0;
                    end else if (wr[i]) begin
                        mD[i] = WrData102;
                        mV[i] = 1'b1;
                    end
                end
            end
        end
        if (!resetN) begin
            hist.delete();
            for (int k = 0; k < DEPTH; k++) hist.push_back('0);
            mA[0] = 15'd1;
            mA[1] = 15'd4;
            mA[2] = 15'd555;
            for (int i = 0; i < NW; i++) begin
                mD[i] = '0;
                mV[i] = 1'b0;
            end
            mCnt  = 0;
            armed = 1'b1;
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        resetN = 1'b0; WrEn102 = 1'b0; WrAddr102 = '0; WrData102 = '0;
        RdAddr102 = '0; RamRdData102 = '0; CfgWrEn = 1'b0; CfgIdx = '0;
        CfgAddr = '0; CntClr = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state plus forwarding at age 1
        applyStimulus(1'b1, 15'h0010, 16'hBEEF, 15'h0000, 16'h0000);
        @(negedge clk);
        checkOutput("reset WatchAddr", 64'(WatchAddr), 64'({15'd555, 15'd4, 15'd1}));
        checkOutput("reset WatchValid", 64'(WatchValid101), 64'h0);
        checkOutput("reset FwdHitCnt", 64'(FwdHitCnt), 64'h0);
        checkOutput("reset FwdHit", 64'(FwdHit102), 64'h0);
        applyStimulus(1'b0, 15'h0000, 16'h0000, 15'h0010, 16'h0000);
        @(negedge clk);
        checkOutput("age1 RdData", 64'(RdData102), 64'hBEEF);
        checkOutput("age1 FwdHit", 64'(FwdHit102), 64'h1);
        applyStimulus(1'b0, 15'h0000, 16'h0000, 15'h0020, 16'h1234);
        @(negedge clk);
        checkOutput("age1 count", 64'(FwdHitCnt), 64'h1);
        checkOutput("miss RdData", 64'(RdData102), 64'h1234);

        // Same-cycle write not forwarded, youngest-first, age-out
        applyStimulus(1'b1, 15'h0010, 16'h1111, 15'h0030, 16'h0000);
        applyStimulus(1'b1, 15'h0010, 16'h2222, 15'h0010, 16'h9999);
        @(negedge clk);
        checkOutput("samecyc RdData", 64'(RdData102), 64'h1111);
        applyStimulus(1'b0, 15'h0000, 16'h0000, 15'h0010, 16'h0000);
        @(negedge clk);
        checkOutput("prio RdData", 64'(RdData102), 64'h2222);
        applyStimulus(1'b0, 15'h0000, 16'h0000, 15'h0010, 16'h0000);
        @(negedge clk);
        checkOutput("entry1 RdData", 64'(RdData102), 64'h2222);
        checkOutput("entry1 FwdHit", 64'(FwdHit102), 64'h1);
        applyStimulus(1'b0, 15'h0000, 16'h0000, 15'h0010, 16'h2222);
        @(negedge clk);
        checkOutput("aged FwdHit", 64'(FwdHit102), 64'h0);
        checkOutput("aged RdData", 64'(RdData102), 64'h2222);
        checkOutput("aged count", 64'(FwdHitCnt), 64'h4);

        // Watch write-through and hold
        applyStimulus(1'b1, 15'd555, 16'h0042, 15'h0040, 16'h0000);
        @(negedge clk);
        checkOutput("wt data2", 64'(WatchData101[2]), 64'h42);
        checkOutput("wt valid2", 64'(WatchValid101[2]), 64'h1);
        applyStimulus(1'b1, 15'd556, 16'h0099, 15'h0040, 16'h0000);
        @(negedge clk);
        checkOutput("hold data2", 64'(WatchData101[2]), 64'h42);
        checkOutput("hold valid2", 64'(WatchValid101[2]), 64'h1);

        // Config beats same-cycle write, then retargeted mirror tracks new address
        applyStimulus(1'b1, 15'd4, 16'h7777, 15'h0040, 16'h0000);
        CfgWrEn = 1'b1; CfgIdx = 2'd1; CfgAddr = 15'h0100;
        @(negedge clk);
        checkOutput("cfg wt suppressed", 64'(WatchData101[1]), 64'h0);
        applyStimulus(1'b0, 15'h0000, 16'h0000, 15'h0040, 16'h0000);
        @(negedge clk);
        checkOutput("cfg addr1", 64'(WatchAddr[1]), 64'h100);
        checkOutput("cfg data1", 64'(WatchData101[1]), 64'h0);
        checkOutput("cfg valid1", 64'(WatchValid101[1]), 64'h0);
        applyStimulus(1'b1, 15'h0100, 16'h0005, 15'h0040, 16'h0000);
        CfgWrEn = 1'b1; CfgIdx = 2'd3; CfgAddr = 15'h0007;
        @(negedge clk);
        checkOutput("newaddr data1", 64'(WatchData101[1]), 64'h5);
        applyStimulus(1'b0, 15'h0000, 16'h0000, 15'h0040, 16'h0000);
        @(negedge clk);
        checkOutput("cfg idx3 ignored", 64'(WatchAddr), 64'({15'd555, 15'h0100, 15'd1}));

        // Counter saturation and clear
        for (int i = 0; i < 65542; i++) begin
            applyStimulus(1'b1, 15'h0050, 16'(i), 15'h0050, 16'h0000);
        end
        @(negedge clk);
        checkOutput("sat count", 64'(FwdHitCnt), 64'hFFFF);
        applyStimulus(1'b1, 15'h0050, 16'h0001, 15'h0050, 16'h0000);
        CntClr = 1'b1;
        @(negedge clk);
        checkOutput("clr hit", 64'(FwdHit102), 64'h1);
        applyStimulus(1'b0, 15'h0000, 16'h0000, 15'h0060, 16'h0000);
        @(negedge clk);
        checkOutput("clr count", 64'(FwdHitCnt), 64'h0);

        // Reset mid-stream with pending entries
        applyStimulus(1'b1, 15'h0070, 16'hAAAA, 15'h0000, 16'h0000);
        applyStimulus(1'b1, 15'h0070, 16'hBBBB, 15'h0070, 16'h0C0C);
        resetN = 1'b0;
        applyStimulus(1'b0, 15'h0000, 16'h0000, 15'h0070, 16'h0C0C);
        @(negedge clk);
        checkOutput("post-rst RdData", 64'(RdData102), 64'h0C0C);
        checkOutput("post-rst FwdHit", 64'(FwdHit102), 64'h0);
        checkOutput("post-rst WatchAddr", 64'(WatchAddr), 64'({15'd555, 15'd4, 15'd1}));
        checkOutput("post-rst WatchValid", 64'(WatchValid101), 64'h0);
        checkOutput("post-rst count", 64'(FwdHitCnt), 64'h0);

        @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/mem_fwd_watch.md
Name: mem_fwd_watch

Overview:
- Parametrised data-memory hazard and mirror unit for the pipelined HACK core.
- Generalises the fixed two-stage write-forwarding (103/104) and the hard-wired M[1]/M[4]/M[555] local copies. Forwarding depth and the number of mirrored addresses are parameters.
- Mirrored addresses are reprogrammable at run time, and the block adds a forward-hit performance counter.
- Sits beside the data RAM: writes and reads are presented at stage 102, mirror data is presented at stage 101.

Parameters:
- DATA_W, 16, data width.
- ADDR_W, 15, address width; the full width is compared.
- DEPTH, 2, in-flight write entries tracked (>=1); equals the RAM write-to-read visibility latency.
- NUM_WATCH, 3, mirrored address registers (>=1).
- WATCH_RST_ADDR, {15'd555,15'd4,15'd1}, packed NUM_WATCH x ADDR_W reset addresses; index 0 is the LSB slice.
- CNT_W, 16, width of the hit counter.

Ports:
- clk  in  1  clock.
- resetN  in  1  synchronous reset, active-low.
- WrEn102  in  1  data-memory write this cycle.
- WrAddr102  in  ADDR_W  write address.
- WrData102  in  DATA_W  write data.
- RdAddr102  in  ADDR_W  address of the read being consumed in 102.
- RamRdData102  in  DATA_W  raw RAM read data.
- RdData102  out  DATA_W  forwarded-or-RAM read data.
- FwdHit102  out  1  RdData102 came from an in-flight entry.
- CfgWrEn  in  1  reprogram one watch address.
- CfgIdx  in  $clog2(NUM_WATCH) (min 1)  watch index.
- CfgAddr  in  ADDR_W  new watch address.
- WatchData101  out  NUM_WATCH x DATA_W  mirror values with write-through.
- WatchValid101  out  NUM_WATCH  mirror has been written since reset or config.
- WatchAddr  out  NUM_WATCH x ADDR_W  current watch addresses.
- CntClr  in  1  clear the hit counter.
- FwdHitCnt  out  CNT_W  saturating forward-hit count.

Behaviour:
- Reset is synchronous on clk when resetN=0. It clears entry valid bits, entry data/address, watch data, WatchValid and FwdHitCnt to 0, and loads WatchAddr from WATCH_RST_ADDR.
- Combinational outputs during reset follow these cleared registers. FwdHit102=0 and RdData102=RamRdData102.
- In-flight write pipeline: a shift register of DEPTH entries {valid, addr, data}.
  - Every cycle, entry0 <= {WrEn102, WrAddr102, WrData102} and entry k <= entry k-1.
  - The pipeline never stalls.
  - Entry k holds the write issued k+1 cycles earlier.
  - A write with WrEn102=0 enters as an invalid entry.
- Read forwarding is combinational.
  - Hit condition: valid_k && addr_k==RdAddr102.
  - Priority is youngest first (lowest k).
  - On a hit: RdData102=data_k and FwdHit102=1. Otherwise RdData102=RamRdData102.
  - A write in the same cycle (WrEn102 with WrAddr102==RdAddr102) is NOT forwarded; it is the same instruction.
- Watch registers, per index i:
  - If WrEn102 && WrAddr102==WatchAddr[i] && !(CfgWrEn && CfgIdx==i), then data_i <= WrData102 and valid_i <= 1.
  - WatchData101[i] is write-through: it shows WrData102 in the same cycle as a matching write, otherwise the registered data_i. WatchValid101[i] is write-through in the same way.
  - Duplicate watch addresses are legal; all matching entries update.
- Config:
  - CfgWrEn sets WatchAddr[CfgIdx] <= CfgAddr, data <= 0 and valid <= 0. It takes effect the next cycle.
  - Config wins over a same-cycle write to that index. Write-through is suppressed for that index in that cycle.
  - CfgIdx >= NUM_WATCH is ignored.
- Counter:
  - FwdHitCnt increments by 1 each cycle FwdHit102=1 and saturates at all-ones.
  - CntClr wins over increment: the count reads 0 the next cycle.
- Latency:
  - Forwarded data and mirror write-through have 0 cycles.
  - Watch register update, config and counter have 1 cycle.

Decomposition:
- cpu_pkg additions:
  - typedef t_fwd_entry {logic valid; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data}. Because the widths are parameters, the package provides 16/15-bit defaults.
  - Constants FWD_DEPTH_DFLT=2 and NUM_WATCH_DFLT=3.
- One natural sub-module, fwd_prio_sel: a combinational youngest-first match/select across DEPTH entries. Watch logic and the counter stay inline.

Test Plan:
- Forwarding at age 1: WrEn102=1, WrAddr=0x0010, WrData=0xBEEF, then next cycle RdAddr=0x0010, RamRdData=0x0000 -> RdData102=0xBEEF, FwdHit102=1, FwdHitCnt=1 one cycle later.
- Youngest-first priority: cycle0 write 0x0010=0x1111, cycle1 write 0x0010=0x2222, cycle2 read 0x0010 -> 0x2222. At cycle3 with no new write, read -> 0x2222 (entry1). At cycle4 (DEPTH=2, entries aged out), read -> RamRdData102=0x2222 and FwdHit102=0.
- Watch write-through: write 555=0x0042 -> WatchData101[2]=0x0042 and WatchValid101[2]=1 in the same cycle, held afterwards. A write to 556 leaves it unchanged.
- Config: CfgWrEn, CfgIdx=1, CfgAddr=0x0100 together with WrEn to addr 4 = 0x7777 -> next cycle WatchAddr[1]=0x0100, WatchData101[1]=0, WatchValid101[1]=0. A later write 0x0100=0x0005 -> 0x0005.
- Counter: force hits for 2^16+3 cycles -> FwdHitCnt=0xFFFF. Assert CntClr during a hit -> next cycle 0.
- Reset mid-stream: pending entries present, drive resetN=0 for one cycle -> next read of that address returns RamRdData102 with FwdHit102=0. WatchAddr returns to {555,4,1}, all WatchValid101=0, FwdHitCnt=0.
